neuron_accum: RTL and testbench
===============================

NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 Parameter NUM_CHUNKS, default 4, SHALL set the number of 20-bit MAC partial sums per neuron; legal range 1..64.
REQ-002 Parameter SHIFT, default 8, SHALL set the requantization right-shift; legal range 0..20.
REQ-003 Parameter ACC_W, default 28, SHALL set the signed accumulator width, sized to hold 64 x (2^20-1) plus a 16-bit bias without overflow.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 sumIn  input  20  SHALL be an unsigned partial sum from the upstream mac stage (16 unsigned 8x8 products).
REQ-007 sumValid  input  1  SHALL qualify sumIn.
REQ-008 inReady  output  1  SHALL be high when the block accepts sumIn this cycle.
REQ-009 biasIn  input  16  SHALL be a signed two's-complement neuron bias, sampled in FINISH.
REQ-010 clear  input  1  SHALL be a synchronous abort of the current neuron.
REQ-011 actOut  output  8  SHALL be the unsigned 8-bit activation.
REQ-012 outValid  output  1  SHALL qualify actOut.
REQ-013 outReady  input  1  SHALL be the downstream acceptance of actOut.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, FINISH, HOLD.
REQ-015 inReady SHALL be 1 in IDLE and ACCUM and 0 in FINISH and HOLD.
REQ-016 A chunk SHALL be accepted only on an edge where sumValid && inReady; sumValid in any other state SHALL be ignored, with no buffering.
REQ-017 On accepting the first chunk (count==0), acc SHALL load zero-extended sumIn; later chunks SHALL add zero-extended sumIn to acc.
REQ-018 Each accepted chunk SHALL increment a chunk counter; on accepting chunk NUM_CHUNKS-1, the counter SHALL return to 0.
REQ-019 In that same accepting case, the state SHALL move to FINISH; otherwise IDLE SHALL move to ACCUM on the first accepted chunk.
REQ-020 With NUM_CHUNKS=1, IDLE SHALL go directly to FINISH.
REQ-021 In FINISH, for exactly one cycle, the block SHALL compute t = acc + sign-extended biasIn.
REQ-022 ReLU: t<0 SHALL yield 0.
REQ-023 Otherwise, t SHALL be logically right-shifted by SHIFT (truncation, no rounding).
REQ-024 The shifted result SHALL be saturated to 255.
REQ-025 The FINISH result SHALL be registered into actOut, with outValid set and the state moved to HOLD.
REQ-026 Latency: if the last chunk is accepted at edge N, outValid SHALL be high from edge N+1.
REQ-027 In HOLD, actOut and outValid SHALL stay stable until an edge with outReady=1.
REQ-028 On that edge, outValid SHALL fall, the state SHALL go to IDLE, and actOut SHALL retain its value.
REQ-029 clear=1 SHALL return the state to IDLE and zero the counter, acc and outValid on that edge, overriding a simultaneous sumValid or outReady.
REQ-030 clear SHALL leave actOut unchanged.
REQ-031 Gaps (sumValid low) between chunks SHALL be allowed, with no timeout.

Reset
REQ-032 While rst_n=0, the block SHALL force state=IDLE, counter=0, acc=0, actOut=8'h00, outValid=0, inReady=1, asynchronously.
REQ-033 Reset asserted mid-accumulation or in HOLD SHALL discard the partial neuron; the first accepted chunk after release SHALL be treated as chunk 0.

Verification
REQ-034 The bench SHALL cover: defaults, bias 0, chunks 0x02044, 0x003A8, 0x00616, 0x00000, outReady=1 -> actOut=0x2A (10754>>8), outValid high exactly one cycle, one edge after the 4th chunk edge.
REQ-035 The bench SHALL cover: four chunks 0xFE010, bias 0 -> actOut=0xFF (saturation).
REQ-036 The bench SHALL cover: chunks 0x02044, 0, 0, 0 with bias -16'sd9000 -> actOut=0x00 (ReLU).
REQ-037 The bench SHALL cover backpressure: outReady held 0 for 5 cycles while sumValid pulses -> actOut/outValid stable, inReady=0, pulses not counted; the next neuron SHALL produce its correct result.
REQ-038 The bench SHALL cover reset mid-operation: rst_n pulsed low after 2 chunks -> outputs reset immediately; the next 4 chunks 0x00100 each with bias 0 -> actOut=0x04.
REQ-039 The bench SHALL cover clear: clear asserted after 3 chunks together with sumValid -> no output; the following 4 chunks 0x00100 -> actOut=0x04.

Source files
------------

// File: rtl/neuron_accum.sv
// Purpose : accumulates NUM_CHUNKS unsigned 20-bit MAC partial sums, adds a signed
//           bias, then applies ReLU, a logical right shift and saturation to 8 bits.
// Latency : outValid rises one clock after the edge that accepts the last chunk.
// Backpr. : inReady drops from the last chunk until the result is taken (outReady);
//           sumValid pulses while inReady=0 are dropped. actOut holds until accepted.
// Ports   : clk, rst_n (async, active-low)
//           sumIn[19:0]/sumValid/inReady   - partial-sum input handshake
//           biasIn[15:0]                   - signed bias, sampled in FINISH
//           clear                          - synchronous abort of current neuron
//           actOut[7:0]/outValid/outReady  - activation output handshake
module neuron_accum #(
  parameter int NUM_CHUNKS = 4,
  parameter int SHIFT      = 8,
  parameter int ACC_W      = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] sumIn,
  input  logic        sumValid,
  output logic        inReady,
  input  logic [15:0] biasIn,
  input  logic        clear,
  output logic [7:0]  actOut,
  output logic        outValid,
  input  logic        outReady
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_act;
  logic             r_out_vld;
  logic             r_in_rdy;

  logic [ACC_W-1:0] w_sum_ext;
  logic [ACC_W:0]   w_bias_ext;
  logic [ACC_W:0]   w_t;
  logic [ACC_W:0]   w_shifted;
  logic [7:0]       w_act;

  assign w_sum_ext  = {{(ACC_W-20){1'b0}}, sumIn};
  assign w_bias_ext = {{(ACC_W+1-16){biasIn[15]}}, biasIn};

  // One extra bit so the sign of acc + bias is never lost; acc itself is never negative.
  assign w_t       = {1'b0, r_acc} + w_bias_ext;
  assign w_shifted = w_t >> SHIFT;

  always_comb begin
    w_act = 8'h00;
    if (w_t[ACC_W]) begin
      w_act = 8'h00;                         // ReLU
    end else if (w_shifted > (ACC_W+1)'(255)) begin
      w_act = 8'hFF;                         // saturate
    end else begin
      w_act = w_shifted[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_act     <= 8'h00;
      r_out_vld <= 1'b0;
      r_in_rdy  <= 1'b1;
    end else if (clear) begin
      // Abort wins over any simultaneous chunk or output acceptance; actOut is kept.
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_out_vld <= 1'b0;
      r_in_rdy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (sumValid) begin
            // First chunk loads rather than adds, so stale acc never leaks in.
            if (r_cnt == '0) begin
              r_acc <= w_sum_ext;
            end else begin
              r_acc <= r_acc + w_sum_ext;
            end
            if (r_cnt == LAST_CNT) begin
              r_cnt    <= '0;
              r_state  <= FINISH;
              r_in_rdy <= 1'b0;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= ACCUM;
            end
          end
        end
        FINISH: begin
          r_act     <= w_act;
          r_out_vld <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (outReady) begin
            r_out_vld <= 1'b0;
            r_state   <= IDLE;
            r_in_rdy  <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_in_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign inReady  = r_in_rdy;
  assign actOut   = r_act;
  assign outValid = r_out_vld;

endmodule

// File: tb/tb_neuron_accum.sv
// Purpose : directed self-checking bench for neuron_accum with an expected-result queue.
// Latency : checks outValid one edge after the last accepted chunk, high for one cycle.
// Backpr. : holds outReady low to check stable outputs and dropped input pulses.
module tb_neuron_accum;

  logic        clk;
  logic        rst_n;
  logic [19:0] sumIn;
  logic        sumValid;
  logic        inReady;
  logic [15:0] biasIn;
  logic        clear;
  logic [7:0]  actOut;
  logic        outValid;
  logic        outReady;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];

  neuron_accum #(.NUM_CHUNKS(4), .SHIFT(8), .ACC_W(28)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sumIn    (sumIn),
    .sumValid (sumValid),
    .inReady  (inReady),
    .biasIn   (biasIn),
    .clear    (clear),
    .actOut   (actOut),
    .outValid (outValid),
    .outReady (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ReLU, >>8 truncation, saturate to 255.
  function automatic logic [7:0] model(input longint sum, input longint bias);
    longint t;
    t = sum + bias;
    if (t < 0) return 8'h00;
    t = t >>> 8;
    if (t > 255) return 8'hFF;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic push_chunk(input logic [19:0] v);
    sumIn    = v;
    sumValid = 1'b1;
    @(posedge clk); #1;
    sumValid = 1'b0;
    sumIn    = '0;
  endtask

  task automatic wait_out(input string tag);
    int cyc;
    cyc = 0;
    while (!outValid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_vld"}, 32'(outValid), 32'd1);
    chk({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk({tag, "_act"}, 32'(actOut), 32'(exp_q.pop_front()));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sumIn    = '0;
    sumValid = 1'b0;
    biasIn   = '0;
    clear    = 1'b0;
    outReady = 1'b1;

    // Reset state
    #12;
    chk("rst_act", 32'(actOut), 32'h00);
    chk("rst_vld", 32'(outValid), 32'd0);
    chk("rst_rdy", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic neuron: 10754 >> 8 = 0x2A, latency and one-cycle pulse
    exp_q.push_back(8'h2A);
    push_chunk(20'h02044);
    push_chunk(20'h003A8);
    push_chunk(20'h00616);
    push_chunk(20'h00000);
    chk("lat_edgeN", 32'(outValid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edgeN1_vld", 32'(outValid), 32'd1);
    chk("lat_edgeN1_act", 32'(actOut), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    chk("pulse_one_cycle", 32'(outValid), 32'd0);
    chk("rdy_after", 32'(inReady), 32'd1);
    chk("act_retained", 32'(actOut), 32'h2A);

    // Saturation
    exp_q.push_back(8'hFF);
    repeat (4) push_chunk(20'hFE010);
    wait_out("sat");
    @(posedge clk); #1;

    // ReLU with negative bias (8260 - 9000 < 0), with gaps between chunks
    biasIn = -16'sd9000;
    exp_q.push_back(8'h00);
    push_chunk(20'h02044);
    @(posedge clk); #1;
    push_chunk(20'h00000);
    repeat (3) @(posedge clk);
    #1;
    push_chunk(20'h00000);
    push_chunk(20'h00000);
    wait_out("relu");
    @(posedge clk); #1;
    biasIn = '0;

    // Backpressure: 4 x 0x1000 = 16384 >> 8 = 0x40, held while inputs pulse
    outReady = 1'b0;
    exp_q.push_back(8'h40);
    repeat (4) push_chunk(20'h01000);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      sumIn    = 20'hFFFFF;
      sumValid = (i % 2) == 0;
      @(posedge clk); #1;
      chk("bp_hold_vld", 32'(outValid), 32'd1);
      chk("bp_hold_act", 32'(actOut), 32'h40);
      chk("bp_hold_rdy", 32'(inReady), 32'd0);
    end
    sumValid = 1'b0;
    sumIn    = '0;
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(outValid), 32'd0);
    biasIn = 16'sd100;
    exp_q.push_back(model(64'h300 + 64'h500 + 64'h700 + 64'h900, 100));
    push_chunk(20'h00300);
    push_chunk(20'h00500);
    push_chunk(20'h00700);
    push_chunk(20'h00900);
    wait_out("bp_next");
    @(posedge clk); #1;
    biasIn = '0;

    // Asynchronous reset mid-accumulation
    push_chunk(20'h10000);
    push_chunk(20'h10000);
    rst_n = 1'b0;
    #1;
    chk("arst_act", 32'(actOut), 32'h00);
    chk("arst_vld", 32'(outValid), 32'd0);
    chk("arst_rdy", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h04);
    repeat (4) push_chunk(20'h00100);
    wait_out("after_rst");
    @(posedge clk); #1;

    // Clear together with a chunk after 3 chunks: no output, actOut kept
    repeat (3) push_chunk(20'h10000);
    sumIn    = 20'h10000;
    sumValid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    sumValid = 1'b0;
    sumIn    = '0;
    clear    = 1'b0;
    chk("clr_rdy", 32'(inReady), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_out", 32'(outValid), 32'd0);
    chk("clr_act_kept", 32'(actOut), 32'h04);
    exp_q.push_back(model(64'h400, 0));
    repeat (4) push_chunk(20'h00100);
    wait_out("after_clr");
    @(posedge clk); #1;
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
